// File: rtl/vp_pkg.sv
// vp_pkg: shared video-pipeline FSM encoding and window-validity helper
package vp_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} vp_state_e;
  function automatic logic win_valid(input logic [31:0] sx, ex, sy, ey, hmax, vmax);
    return (sx < ex) && (sy < ey) && (ex <= hmax) && (ey <= vmax);
  endfunction
endpackage

// File: rtl/pixel_pos_cnt.sv
// pixel_pos_cnt: saturating x/y position tracker driven by de and a frame clear
module pixel_pos_cnt #(
  parameter int X_W = 12,
  parameter int Y_W = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           de,
  output logic [X_W-1:0] x_cur,
  output logic [Y_W-1:0] y_cur,
  output logic           de_fall
);
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           de_d;
  assign de_fall = de_d & ~de;
  assign x_cur   = clr ? '0 : x;
  assign y_cur   = clr ? '0 : y;
  // position of the next pixel; a clearing pixel is (0,0) so x resumes at 1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      de_d <= 1'b0;
    end else begin
      de_d <= de;
      if (clr) begin
        x <= de ? X_W'(1) : '0;
        y <= '0;
      end else if (de) begin
        x <= &x ? x : x + 1'b1;
      end else if (de_fall) begin
        x <= '0;
        y <= &y ? y : y + 1'b1;
      end
    end
endmodule

// File: rtl/image_crop.sv
// image_crop: crops a DE-framed video stream to a per-frame latched window
module image_crop
  import vp_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int H_DISP = 1920,
  parameter int V_DISP = 1080,
  parameter int X_W    = 12,
  parameter int Y_W    = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              crop_en,
  input  logic [X_W-1:0]    start_x,
  input  logic [X_W-1:0]    end_x,
  input  logic [Y_W-1:0]    start_y,
  input  logic [Y_W-1:0]    end_y,
  input  logic              vs_i,
  input  logic              de_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              vs_o,
  output logic              de_o,
  output logic [DATA_W-1:0] data_o,
  output logic              sof_o,
  output logic              eol_o,
  output logic              active_o,
  output logic              cfg_err_o
);
  vp_state_e      state, state_nx;
  logic           vs_d, fs;
  logic           sh_en, en_e, act_e, valid_e, in_win, pass, sof_n, eol_n, de_fall;
  logic [X_W-1:0] sh_sx, sh_ex, sx_e, ex_e, x_cur;
  logic [Y_W-1:0] sh_sy, sh_ey, sy_e, ey_e, y_cur;
  assign fs = vs_i & ~vs_d;
  // a frame-start pixel already belongs to the new frame, so bypass the shadows then
  assign en_e  = fs ? crop_en : sh_en;
  assign sx_e  = fs ? start_x : sh_sx;
  assign ex_e  = fs ? end_x   : sh_ex;
  assign sy_e  = fs ? start_y : sh_sy;
  assign ey_e  = fs ? end_y   : sh_ey;
  assign act_e = state_nx == ST_ACTIVE;
  assign valid_e = win_valid(32'(sx_e), 32'(ex_e), 32'(sy_e), 32'(ey_e), 32'(H_DISP), 32'(V_DISP));
  assign in_win  = (x_cur >= sx_e) && (x_cur < ex_e) && (y_cur >= sy_e) && (y_cur < ey_e);
  assign pass    = de_i & act_e & (en_e ? valid_e & in_win : 1'b1);
  assign sof_n   = pass & (en_e ? (x_cur == sx_e) && (y_cur == sy_e) : (x_cur == '0) && (y_cur == '0));
  assign eol_n   = en_e ? pass & (x_cur == ex_e - 1'b1) : act_e & de_fall;
  pixel_pos_cnt #(.X_W(X_W), .Y_W(Y_W)) u_pos (
    .clk(clk), .rst_n(rst_n), .clr(fs), .de(de_i),
    .x_cur(x_cur), .y_cur(y_cur), .de_fall(de_fall)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  // leave IDLE on the first frame start, then stay ACTIVE
  always_comb begin
    state_nx = state;
    state_nx = (state == ST_IDLE && fs) ? ST_ACTIVE : state;
  end
  // window shadows follow the inputs only at frame start
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vs_d  <= 1'b0;
      sh_en <= 1'b0;
      sh_sx <= '0;
      sh_ex <= '0;
      sh_sy <= '0;
      sh_ey <= '0;
    end else begin
      vs_d <= vs_i;
      if (fs) begin
        sh_en <= crop_en;
        sh_sx <= start_x;
        sh_ex <= end_x;
        sh_sy <= start_y;
        sh_ey <= end_y;
      end
    end
  // one-cycle registered output stage
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vs_o      <= 1'b0;
      de_o      <= 1'b0;
      data_o    <= '0;
      sof_o     <= 1'b0;
      eol_o     <= 1'b0;
      active_o  <= 1'b0;
      cfg_err_o <= 1'b0;
    end else begin
      vs_o      <= vs_i;
      de_o      <= pass;
      data_o    <= pass ? data_i : '0;
      sof_o     <= sof_n;
      eol_o     <= eol_n;
      active_o  <= act_e;
      cfg_err_o <= act_e & en_e & ~valid_e;
    end
endmodule
